reservation_station: RTL
========================

RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 Parameter DEPTH, default 4, number of entries.
REQ-003 Parameter TAG_WIDTH, default 6, ROB tag width.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 flush  in  1  discard all entries and any pending broadcast.
REQ-007 dispatch_valid / dispatch_ready  in / out  1 / 1  dispatch handshake.
REQ-008 dispatch_control_signals  in  11  control word; [10:7] = FU func_sel, [5] = link-PC select.
REQ-009 dispatch_pc, dispatch_branch_sel, dispatch_branch_prediction  in  DATA_WIDTH, 3, 1  carried unchanged to FU.
REQ-010 dispatch_rob_tag  in  TAG_WIDTH  destination tag.
REQ-011 dispatch_a_valid, dispatch_a_data, dispatch_a_tag  in  1, DATA_WIDTH, TAG_WIDTH  operand A (data if valid, else producer tag); same triple for B.
REQ-012 cdb_in_valid[2:0], cdb_in_tag[3x TAG_WIDTH], cdb_in_data[3x DATA_WIDTH]  in  snooped broadcast ports, one per FU.
REQ-013 issue_valid  out  1; issue_ready  in  1 (FU not busy); handshake when both high.
REQ-014 data_a, data_b, control_signals, pc, branch_sel, branch_prediction  out  issued payload to FU.
REQ-015 data_result  in  DATA_WIDTH  combinational FU result for the currently issued payload.
REQ-016 cdb_out_valid, cdb_out_tag, cdb_out_data  out  1, TAG_WIDTH, DATA_WIDTH  this unit's result broadcast.

Function
REQ-017 Each entry SHALL hold busy, payload, rob_tag, and per operand {valid, data, tag}.
REQ-018 dispatch_ready SHALL be 1 iff at least one entry is free at cycle start; an entry freed by issue in cycle N is reusable from cycle N+1.
REQ-019 On a dispatch handshake, the lowest-index free entry SHALL be written.
REQ-020 Dispatch bypass: an operand dispatched not-valid whose tag matches a valid cdb_in port in the same cycle SHALL be stored valid with that port's data.
REQ-021 Each busy entry with a not-valid operand SHALL capture data and set valid on a matching valid cdb_in port.
REQ-022 On multiple matching ports, the lowest port index SHALL win.
REQ-023 An entry SHALL be issuable when busy and both operands valid at cycle start; no same-cycle wakeup-to-issue (capture in N, earliest issue N+1).
REQ-024 Among issuable entries, the earliest dispatched SHALL be selected; issue_valid = any issuable entry.
REQ-025 Issue payload outputs SHALL be driven combinationally from the selected entry; when issue_valid=0 they SHALL be 0.
REQ-026 On an issue handshake, the selected entry SHALL be freed, and cdb_out_tag/cdb_out_data SHALL register rob_tag and data_result, with cdb_out_valid=1 in the following cycle only (latency 1 cycle from handshake).
REQ-027 issue_valid high with issue_ready low SHALL hold the selection stable; no entry is freed.
REQ-028 The entry leaving in cycle N SHALL not be affected by a cdb_in match in cycle N.
REQ-029 flush SHALL free all entries and force cdb_out_valid=0 next cycle; flush has priority over dispatch, capture and issue in the same cycle.

Reset
REQ-030 rst=1 at an edge SHALL clear all busy/valid bits and age state and set cdb_out_valid=0, cdb_out_tag=0, cdb_out_data=0; dispatch_ready=1, issue_valid=0 afterwards.
REQ-031 rst mid-operation SHALL discard in-flight entries and any pending broadcast; rst has priority over flush.

Verification
REQ-032 Dispatch A=5, B=7 both valid, func ADD, tag 3, issue_ready=1 -> issue_valid next cycle with data_a=5, data_b=7; cycle after, cdb_out_valid=1, tag=3, data=12.
REQ-033 Dispatch A pending on tag 9; cdb_in[1] valid tag 9 data 0x10 two cycles later -> issue_valid asserts one cycle after capture, data_a=0x10.
REQ-034 Dispatch A tag 4 pending while cdb_in[2] broadcasts tag 4 data 0xAA same cycle -> entry stored valid, issues next cycle with data_a=0xAA.
REQ-035 Fill 4 entries with issue_ready=0 -> dispatch_ready=0, 5th dispatch_valid ignored; raise issue_ready -> entries issue in dispatch order, one per cycle.
REQ-036 Two pending entries, assert flush together with a cdb_in match and a dispatch -> next cycle all entries free, issue_valid=0, cdb_out_valid=0, dispatch_ready=1.
REQ-037 Assert rst while an issue handshake occurs -> cdb_out_valid=0 next cycle and no entry remains busy.

Source files
------------

// File: rtl/reservation_station_if.sv
// Handshake and bus bundle between dispatch, CDB, the reservation station and its functional unit.
// master = the side that drives dispatch, CDB snoop and FU result; slave = the station itself.
interface reservation_station_if #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6
);
  logic                    flush;

  logic                    dispatch_valid;
  logic                    dispatch_ready;
  logic [10:0]             dispatch_control_signals;
  logic [DATA_WIDTH-1:0]   dispatch_pc;
  logic [2:0]              dispatch_branch_sel;
  logic                    dispatch_branch_prediction;
  logic [TAG_WIDTH-1:0]    dispatch_rob_tag;
  logic                    dispatch_a_valid;
  logic [DATA_WIDTH-1:0]   dispatch_a_data;
  logic [TAG_WIDTH-1:0]    dispatch_a_tag;
  logic                    dispatch_b_valid;
  logic [DATA_WIDTH-1:0]   dispatch_b_data;
  logic [TAG_WIDTH-1:0]    dispatch_b_tag;

  logic [2:0]              cdb_in_valid;
  logic [3*TAG_WIDTH-1:0]  cdb_in_tag;
  logic [3*DATA_WIDTH-1:0] cdb_in_data;

  logic                    issue_valid;
  logic                    issue_ready;
  logic [DATA_WIDTH-1:0]   data_a;
  logic [DATA_WIDTH-1:0]   data_b;
  logic [10:0]             control_signals;
  logic [DATA_WIDTH-1:0]   pc;
  logic [2:0]              branch_sel;
  logic                    branch_prediction;
  logic [DATA_WIDTH-1:0]   data_result;

  logic                    cdb_out_valid;
  logic [TAG_WIDTH-1:0]    cdb_out_tag;
  logic [DATA_WIDTH-1:0]   cdb_out_data;

  modport master (
    output flush,
    output dispatch_valid, dispatch_control_signals, dispatch_pc, dispatch_branch_sel,
    output dispatch_branch_prediction, dispatch_rob_tag,
    output dispatch_a_valid, dispatch_a_data, dispatch_a_tag,
    output dispatch_b_valid, dispatch_b_data, dispatch_b_tag,
    output cdb_in_valid, cdb_in_tag, cdb_in_data,
    output issue_ready, data_result,
    input  dispatch_ready, issue_valid,
    input  data_a, data_b, control_signals, pc, branch_sel, branch_prediction,
    input  cdb_out_valid, cdb_out_tag, cdb_out_data
  );

  modport slave (
    input  flush,
    input  dispatch_valid, dispatch_control_signals, dispatch_pc, dispatch_branch_sel,
    input  dispatch_branch_prediction, dispatch_rob_tag,
    input  dispatch_a_valid, dispatch_a_data, dispatch_a_tag,
    input  dispatch_b_valid, dispatch_b_data, dispatch_b_tag,
    input  cdb_in_valid, cdb_in_tag, cdb_in_data,
    input  issue_ready, data_result,
    output dispatch_ready, issue_valid,
    output data_a, data_b, control_signals, pc, branch_sel, branch_prediction,
    output cdb_out_valid, cdb_out_tag, cdb_out_data
  );
endinterface

// File: rtl/reservation_station.sv
// Reservation station: holds dispatched ops until both operands arrive via CDB snooping,
// issues the oldest ready op to its FU and broadcasts the FU result one cycle later.
module reservation_station #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int TAG_WIDTH  = 6
) (
  input logic                   clk,
  input logic                   rst,
  reservation_station_if.slave  rs
);

  localparam int PORTS = 3;

  // Returns {hit, data}; scanning from the top port down lets the lowest matching port win.
  function automatic logic [DATA_WIDTH:0] snoop(
    input logic [TAG_WIDTH-1:0]        tag,
    input logic [PORTS-1:0]            valid,
    input logic [PORTS*TAG_WIDTH-1:0]  tags,
    input logic [PORTS*DATA_WIDTH-1:0] datas
  );
    logic [DATA_WIDTH:0] hit;
    hit = '0;
    for (int p = PORTS - 1; p >= 0; p--) begin
      if (valid[p] && (tags[p*TAG_WIDTH +: TAG_WIDTH] == tag)) begin
        hit = {1'b1, datas[p*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
    return hit;
  endfunction

  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      a_valid;
  logic [DEPTH-1:0]      b_valid;
  logic [DEPTH-1:0]      issuable;
  logic [DEPTH-1:0]      issue_sel;
  logic [DEPTH-1:0]      free;
  logic [DEPTH-1:0]      disp_sel;
  logic [DEPTH-1:0]      older [DEPTH];
  logic [DATA_WIDTH-1:0] ent_a_data [DEPTH];
  logic [DATA_WIDTH-1:0] ent_b_data [DEPTH];
  logic [DATA_WIDTH-1:0] ent_pc [DEPTH];
  logic [10:0]           ent_ctrl [DEPTH];
  logic [2:0]            ent_bsel [DEPTH];
  logic [DEPTH-1:0]      ent_bpred;
  logic [TAG_WIDTH-1:0]  ent_rob_tag [DEPTH];

  logic                  dispatch_ready_w;
  logic                  issue_valid_w;
  logic                  dispatch_fire;
  logic                  issue_fire;
  logic [DATA_WIDTH:0]   disp_a_hit;
  logic [DATA_WIDTH:0]   disp_b_hit;

  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic [DATA_WIDTH-1:0] sel_pc;
  logic [10:0]           sel_ctrl;
  logic [2:0]            sel_bsel;
  logic                  sel_bpred;
  logic [TAG_WIDTH-1:0]  sel_rob_tag;

  logic                  cdb_out_valid_reg;
  logic [TAG_WIDTH-1:0]  cdb_out_tag_reg;
  logic [DATA_WIDTH-1:0] cdb_out_data_reg;

  assign free             = ~busy;
  assign dispatch_ready_w = |free;
  assign issuable         = busy & a_valid & b_valid;
  assign issue_valid_w    = |issuable;

  assign dispatch_fire = rs.dispatch_valid && dispatch_ready_w && !rs.flush && !rst;
  assign issue_fire    = issue_valid_w && rs.issue_ready && !rs.flush && !rst;

  // Lowest set bit of the free mask picks the target entry.
  assign disp_sel = dispatch_fire ? (free & (~free + DEPTH'(1))) : '0;

  assign disp_a_hit = snoop(rs.dispatch_a_tag, rs.cdb_in_valid, rs.cdb_in_tag, rs.cdb_in_data);
  assign disp_b_hit = snoop(rs.dispatch_b_tag, rs.cdb_in_valid, rs.cdb_in_tag, rs.cdb_in_data);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic                  busy_reg;
      logic                  a_valid_reg;
      logic                  b_valid_reg;
      logic [DATA_WIDTH-1:0] a_data_reg;
      logic [DATA_WIDTH-1:0] b_data_reg;
      logic [TAG_WIDTH-1:0]  a_tag_reg;
      logic [TAG_WIDTH-1:0]  b_tag_reg;
      logic [TAG_WIDTH-1:0]  rob_tag_reg;
      logic [10:0]           ctrl_reg;
      logic [DATA_WIDTH-1:0] pc_reg;
      logic [2:0]            bsel_reg;
      logic                  bpred_reg;
      // older_reg[j] set means this entry was dispatched before entry j.
      logic [DEPTH-1:0]      older_reg;
      logic [DATA_WIDTH:0]   a_hit;
      logic [DATA_WIDTH:0]   b_hit;
      logic                  blocked;

      assign a_hit = snoop(a_tag_reg, rs.cdb_in_valid, rs.cdb_in_tag, rs.cdb_in_data);
      assign b_hit = snoop(b_tag_reg, rs.cdb_in_valid, rs.cdb_in_tag, rs.cdb_in_data);

      always_ff @(posedge clk) begin
        if (rst || rs.flush) begin
          busy_reg    <= 1'b0;
          a_valid_reg <= 1'b0;
          b_valid_reg <= 1'b0;
          older_reg   <= '0;
        end else if (disp_sel[gi]) begin
          busy_reg    <= 1'b1;
          rob_tag_reg <= rs.dispatch_rob_tag;
          ctrl_reg    <= rs.dispatch_control_signals;
          pc_reg      <= rs.dispatch_pc;
          bsel_reg    <= rs.dispatch_branch_sel;
          bpred_reg   <= rs.dispatch_branch_prediction;
          a_tag_reg   <= rs.dispatch_a_tag;
          b_tag_reg   <= rs.dispatch_b_tag;
          a_valid_reg <= rs.dispatch_a_valid || disp_a_hit[DATA_WIDTH];
          b_valid_reg <= rs.dispatch_b_valid || disp_b_hit[DATA_WIDTH];
          a_data_reg  <= rs.dispatch_a_valid ? rs.dispatch_a_data : disp_a_hit[DATA_WIDTH-1:0];
          b_data_reg  <= rs.dispatch_b_valid ? rs.dispatch_b_data : disp_b_hit[DATA_WIDTH-1:0];
          older_reg   <= '0;
        end else begin
          if (issue_fire && issue_sel[gi]) begin
            busy_reg <= 1'b0;
          end
          if (busy_reg && !a_valid_reg && a_hit[DATA_WIDTH]) begin
            a_valid_reg <= 1'b1;
            a_data_reg  <= a_hit[DATA_WIDTH-1:0];
          end
          if (busy_reg && !b_valid_reg && b_hit[DATA_WIDTH]) begin
            b_valid_reg <= 1'b1;
            b_data_reg  <= b_hit[DATA_WIDTH-1:0];
          end
          older_reg <= older_reg | disp_sel;
        end
      end

      // Selected if ready and no other ready entry is older.
      always_comb begin
        blocked = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
          if ((j != gi) && issuable[j] && older[j][gi]) begin
            blocked = 1'b1;
          end
        end
      end

      assign issue_sel[gi]   = issuable[gi] && !blocked;
      assign busy[gi]        = busy_reg;
      assign a_valid[gi]     = a_valid_reg;
      assign b_valid[gi]     = b_valid_reg;
      assign older[gi]       = older_reg;
      assign ent_a_data[gi]  = a_data_reg;
      assign ent_b_data[gi]  = b_data_reg;
      assign ent_pc[gi]      = pc_reg;
      assign ent_ctrl[gi]    = ctrl_reg;
      assign ent_bsel[gi]    = bsel_reg;
      assign ent_bpred[gi]   = bpred_reg;
      assign ent_rob_tag[gi] = rob_tag_reg;
    end
  endgenerate

  // issue_sel is one-hot or zero, so OR-ing yields the selected payload or all zeros.
  always_comb begin
    sel_a       = '0;
    sel_b       = '0;
    sel_pc      = '0;
    sel_ctrl    = '0;
    sel_bsel    = '0;
    sel_bpred   = 1'b0;
    sel_rob_tag = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (issue_sel[i]) begin
        sel_a       |= ent_a_data[i];
        sel_b       |= ent_b_data[i];
        sel_pc      |= ent_pc[i];
        sel_ctrl    |= ent_ctrl[i];
        sel_bsel    |= ent_bsel[i];
        sel_bpred   |= ent_bpred[i];
        sel_rob_tag |= ent_rob_tag[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_out_valid_reg <= 1'b0;
      cdb_out_tag_reg   <= '0;
      cdb_out_data_reg  <= '0;
    end else if (rs.flush) begin
      cdb_out_valid_reg <= 1'b0;
    end else begin
      cdb_out_valid_reg <= issue_fire;
      if (issue_fire) begin
        cdb_out_tag_reg  <= sel_rob_tag;
        cdb_out_data_reg <= rs.data_result;
      end
    end
  end

  assign rs.dispatch_ready    = dispatch_ready_w;
  assign rs.issue_valid       = issue_valid_w;
  assign rs.data_a            = sel_a;
  assign rs.data_b            = sel_b;
  assign rs.control_signals   = sel_ctrl;
  assign rs.pc                = sel_pc;
  assign rs.branch_sel        = sel_bsel;
  assign rs.branch_prediction = sel_bpred;
  assign rs.cdb_out_valid     = cdb_out_valid_reg;
  assign rs.cdb_out_tag       = cdb_out_tag_reg;
  assign rs.cdb_out_data      = cdb_out_data_reg;

endmodule
